pair_buffer: RTL and testbench
==============================

PAIR_BUFFER -- requirements
Module: pair_buffer

Interface
REQ-001 Parameter WIDTH, default 16, bit width of each real/imaginary sample part, two's-complement signed.
REQ-002 Parameter LOG2N, default 4, log2 of frame length N; half-frame H = N/2; legal range LOG2N >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input sample present this cycle.
REQ-006 in_sof  input  1  marks the first sample of a frame; qualified by in_valid.
REQ-007 in_re, in_im  input  WIDTH each  input sample, signed.
REQ-008 out_valid  output  1  butterfly operand pair valid this cycle.
REQ-009 a_re, a_im  output  WIDTH each  first-half sample x[k], signed.
REQ-010 b_re, b_im  output  WIDTH each  second-half sample x[k+H], signed.
REQ-011 tw_idx  output  LOG2N-1  pair index k, used by the downstream butterfly as its twiddle address.
REQ-012 frame_done  output  1  present only with PAIR_BUF_FRAME_DONE_EN; see REQ-027.

Function
REQ-013 The block SHALL pair sample k with sample k+H of each N-sample frame for the downstream radix-2 butterfly.
REQ-014 A log2(H)-bit counter cnt SHALL advance only on accepted samples (in_valid=1); gaps hold all state.
REQ-015 There SHALL be two states: FILL and PAIR.
REQ-016 FILL: accepted sample written to buffer address cnt; at cnt=H-1, cnt wraps to 0 and state goes to PAIR.
REQ-017 PAIR: accepted sample SHALL issue a buffer read at address cnt and register the sample as b; at cnt=H-1, cnt wraps to 0 and state goes to FILL.
REQ-018 Latency: out_valid SHALL assert exactly one cycle after each accepted PAIR sample, with a = buffer[cnt], b = that sample, tw_idx = cnt as sampled at acceptance.
REQ-019 out_valid SHALL be a single-cycle pulse per pair; a, b and tw_idx SHALL hold their last values while out_valid=0.
REQ-020 Accepted in_sof=1 SHALL force the sample to be treated as frame index 0 (FILL, address 0) regardless of current state or cnt; any partially built frame is discarded.
REQ-021 If in_sof aborts a PAIR phase, a pair already issued for output SHALL still emit on the next cycle; no further pairs from the aborted frame SHALL emit.
REQ-022 Back-to-back frames with no idle cycle SHALL be supported; the first FILL write of frame n+1 may occur in the cycle after the last PAIR read of frame n.
REQ-023 No arithmetic SHALL be performed; data passes bit-exact.

Reset
REQ-024 While rst_n=0: state=FILL, cnt=0, out_valid=0, a/b/tw_idx=0, frame_done=0.
REQ-025 Reset mid-frame SHALL discard the frame; after release the next accepted sample is frame index 0 whether or not in_sof is asserted.
REQ-026 Buffer storage SHALL NOT be reset; contents are don't-care until rewritten.

Configuration
REQ-027 Macro PAIR_BUF_FRAME_DONE_EN defined: frame_done port exists and pulses for one cycle, coincident with out_valid, on the pair with tw_idx=H-1.
REQ-028 Macro undefined: frame_done port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package fft_pkg SHALL hold the FILL/PAIR state encoding and the default WIDTH and LOG2N constants.
REQ-030 Sub-module pair_buf_mem SHALL implement H x 2*WIDTH storage: one synchronous write port and one synchronous read port with one-cycle read latency, inferable as block RAM.

Verification (WIDTH=16, LOG2N=3, H=4)
REQ-031 Continuous frame: samples re=1..8, im=-1..-8, sof on the first -> four out_valid pulses with (a_re,b_re,tw_idx) = (1,5,0),(2,6,1),(3,7,2),(4,8,3), each one cycle after the samples 5..8.
REQ-032 Gapped input: same frame with in_valid low every other cycle -> identical pairs; out_valid only one cycle after each accepted second-half sample.
REQ-033 SOF abort: sof at sample 0, then sof again at sample 6 (in PAIR) -> pairs (1,5,0),(2,6,1) only; the new frame fills from address 0 and pairs correctly.
REQ-034 Reset after sample 3 -> outputs zero; a new 8-sample frame without sof pairs correctly from index 0.
REQ-035 Two back-to-back frames -> 8 pairs with no lost or duplicated tw_idx; with PAIR_BUF_FRAME_DONE_EN, frame_done pulses twice, on tw_idx=3.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: constants and state encoding shared by the pair_buffer slice.
//   state_e   : FILL / PAIR phase of the half-frame pairing FSM
//   DEF_WIDTH : default sample part width
//   DEF_LOG2N : default log2 of the frame length
package fft_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LOG2N = 4;

endpackage

// File: rtl/pair_buf_mem.sv
// pair_buf_mem: simple dual-port storage, one synchronous write port and one
// synchronous read port with one-cycle read latency. Storage is not reset so
// it maps onto block RAM.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates on the next edge only when set
//   raddr_i : read address
//   rdata_o : registered read data
module pair_buf_mem #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [1<<AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pair_buffer.sv
// pair_buffer: pairs sample k with sample k+H of each N-sample frame for a
// radix-2 butterfly. The first half of a frame is stored; each second-half
// sample reads its partner back and both leave one cycle later.
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_sof    : sample strobe, start-of-frame (qualified by in_valid)
//   in_re, in_im        : input sample
//   out_valid           : one-cycle pulse per operand pair
//   a_re, a_im          : x[k]
//   b_re, b_im          : x[k+H]
//   tw_idx              : pair index k
//   frame_done          : with PAIR_BUF_FRAME_DONE_EN only; pulses with the
//                         last pair (tw_idx = H-1) of a frame
//
// state | meaning
// FILL  | storing first-half samples at address cnt
// PAIR  | reading partner at cnt, emitting pair next cycle
module pair_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    output logic [WIDTH-1:0] a_re,
    output logic [WIDTH-1:0] a_im,
    output logic [WIDTH-1:0] b_re,
    output logic [WIDTH-1:0] b_im,
    output logic [LOG2N-2:0] tw_idx
`ifdef PAIR_BUF_FRAME_DONE_EN
    ,
    output logic             frame_done
`endif
);

    localparam int AW = LOG2N - 1;
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_en, rd_en;
    logic [AW-1:0]   wr_addr;
    logic [2*WIDTH-1:0] rdata;

    logic            pend_q;
    logic [2*WIDTH-1:0] a_hold_q;
    logic [2*WIDTH-1:0] b_q;
    logic [AW-1:0]   tw_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state; an accepted sof restarts the frame at index 0, so the
    // following sample lands at address 1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            if (in_sof) begin
                state_d = FILL;
                cnt_d   = AW'(1);
            end else begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = (state_q == FILL) ? PAIR : FILL;
                end
            end
        end
    end

    // outputs: memory port controls
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = cnt_q;
        if (in_valid) begin
            if (in_sof) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state_q == FILL) begin
                wr_en = 1'b1;
            end else begin
                rd_en = 1'b1;
            end
        end
    end

    pair_buf_mem #(
        .DW (2*WIDTH),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i ({in_re, in_im}),
        .re_i    (rd_en),
        .raddr_i (cnt_q),
        .rdata_o (rdata)
    );

    // b and tw_idx are captured alongside the read so they line up with the
    // memory data; a_hold_q keeps a stable while no pair is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= 1'b0;
            a_hold_q <= '0;
            b_q      <= '0;
            tw_q     <= '0;
        end else begin
            pend_q <= rd_en;
            if (pend_q) a_hold_q <= rdata;
            if (rd_en) begin
                b_q  <= {in_re, in_im};
                tw_q <= cnt_q;
            end
        end
    end

    assign out_valid    = pend_q;
    assign {a_re, a_im} = pend_q ? rdata : a_hold_q;
    assign {b_re, b_im} = b_q;
    assign tw_idx       = tw_q;

`ifdef PAIR_BUF_FRAME_DONE_EN
    logic fd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fd_q <= 1'b0;
        else        fd_q <= rd_en && (cnt_q == CNT_LAST);
    end

    assign frame_done = fd_q;
`endif

endmodule

// File: tb/tb_pair_buffer.sv
module tb_pair_buffer;

    localparam int W     = 16;
    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;
    localparam int H     = N / 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_sof;
    logic [W-1:0] in_re, in_im;
    logic         out_valid;
    logic [W-1:0] a_re, a_im, b_re, b_im;
    logic [LOG2N-2:0] tw_idx;
`ifdef PAIR_BUF_FRAME_DONE_EN
    logic         frame_done;
`endif

    always #5 clk = ~clk;

    pair_buffer #(.WIDTH(W), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .tw_idx    (tw_idx)
`ifdef PAIR_BUF_FRAME_DONE_EN
        ,
        .frame_done(frame_done)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame index position plus the stored frame samples.
    logic [W-1:0] frm_re [N];
    logic [W-1:0] frm_im [N];
    int           idx;
    logic         exp_valid, exp_fd;
    logic [W-1:0] exp_a_re, exp_a_im, exp_b_re, exp_b_im;
    logic [LOG2N-2:0] exp_tw;
    int           pulse_cnt, fd_cnt;

    task automatic model_reset();
        idx       = 0;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        exp_a_re  = '0; exp_a_im = '0;
        exp_b_re  = '0; exp_b_im = '0;
        exp_tw    = '0;
    endtask

    task automatic model_accept(input logic v, input logic s,
                                input logic [W-1:0] re, input logic [W-1:0] im);
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            if (s) idx = 0;
            frm_re[idx] = re;
            frm_im[idx] = im;
            if (idx >= H) begin
                exp_valid = 1'b1;
                exp_a_re  = frm_re[idx-H];
                exp_a_im  = frm_im[idx-H];
                exp_b_re  = re;
                exp_b_im  = im;
                exp_tw    = (LOG2N-1)'(idx - H);
                exp_fd    = (idx == N-1);
            end
            idx = (idx + 1) % N;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        check({tag, ".a_re"},      64'(a_re),      64'(exp_a_re));
        check({tag, ".a_im"},      64'(a_im),      64'(exp_a_im));
        check({tag, ".b_re"},      64'(b_re),      64'(exp_b_re));
        check({tag, ".b_im"},      64'(b_im),      64'(exp_b_im));
        check({tag, ".tw_idx"},    64'(tw_idx),    64'(exp_tw));
        if (out_valid === 1'b1) pulse_cnt++;
`ifdef PAIR_BUF_FRAME_DONE_EN
        check({tag, ".frame_done"}, 64'(frame_done), 64'(exp_fd));
        if (frame_done === 1'b1) fd_cnt++;
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic s,
                        input logic [W-1:0] re, input logic [W-1:0] im);
        @(negedge clk);
        in_valid = v; in_sof = s; in_re = re; in_im = im;
        @(posedge clk);
        model_accept(v, s, re, im);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // samples re = base+1 .. base+n, im = -(re)
    task automatic send_seq(input string tag, input int base, input int n,
                            input logic sof_first, input logic gap);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] r;
            r = W'(base + i + 1);
            if (gap && i > 0) step(tag, 1'b0, 1'b0, W'($urandom), W'($urandom));
            step(tag, 1'b1, sof_first && (i == 0), r, -r);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
        pulse_cnt = 0; fd_cnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rst_n = 1'b1;

        // continuous frame
        pulse_cnt = 0;
        send_seq("cont", 0, N, 1'b1, 1'b0);
        check("cont.pairs", 64'(pulse_cnt), 64'(H));
        step("cont.idle", 1'b0, 1'b0, '0, '0);

        // gapped frame
        pulse_cnt = 0;
        send_seq("gap", 0, N, 1'b1, 1'b1);
        step("gap.idle", 1'b0, 1'b0, '0, '0);
        check("gap.pairs", 64'(pulse_cnt), 64'(H));

        // sof abort on sample 6 of PAIR phase, then a full new frame
        pulse_cnt = 0;
        send_seq("abort", 0, 6, 1'b1, 1'b0);
        send_seq("abort.new", 100, N, 1'b1, 1'b0);
        step("abort.idle", 1'b0, 1'b0, '0, '0);
        check("abort.pairs", 64'(pulse_cnt), 64'(2 + H));

        // reset after sample 3, then frame without sof
        send_seq("rst3", 0, 3, 1'b1, 1'b0);
        do_reset("rst3.reset");
        pulse_cnt = 0;
        send_seq("rst3.new", 200, N, 1'b0, 1'b0);
        check("rst3.pairs", 64'(pulse_cnt), 64'(H));

        // two back-to-back frames
        pulse_cnt = 0; fd_cnt = 0;
        send_seq("b2b0", 300, N, 1'b1, 1'b0);
        send_seq("b2b1", 400, N, 1'b0, 1'b0);
        step("b2b.idle", 1'b0, 1'b0, '0, '0);
        check("b2b.pairs", 64'(pulse_cnt), 64'(2*H));
`ifdef PAIR_BUF_FRAME_DONE_EN
        check("b2b.frame_done", 64'(fd_cnt), 64'(2));
`endif

        // randomized traffic with occasional sof and reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd.reset");
            end else begin
                step("rnd", ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                     W'($urandom), W'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
